// File: rtl/rat_intr_pkg.sv
// Shared constants and state type for the RAT interrupt controller.
// Build option IRQ_SYNC_EN (see rat_irq_edge) does not change anything here.
package rat_intr_pkg;

    localparam logic [7:0] OFS_STATUS = 8'd0;
    localparam logic [7:0] OFS_MASK   = 8'd1;
    localparam logic [7:0] OFS_VECTOR = 8'd2;

    localparam int VEC_VALID_BIT = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        GAP    = 2'd2
    } intr_state_t;

endpackage

// File: rtl/rat_irq_edge.sv
// Per-source rising-edge detector. Define IRQ_SYNC_EN to insert a 2-flop
// synchronizer ahead of the history flop for asynchronous sources.
module rat_irq_edge (
    input  logic CLK,
    input  logic RESET,
    input  logic irq,
    output logic rise
);

    logic sampled;
    logic hist_reg;

`ifdef IRQ_SYNC_EN
    logic sync1_reg;
    logic sync2_reg;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= irq;
            sync2_reg <= sync1_reg;
        end
    end

    assign sampled = sync2_reg;
`else
    assign sampled = irq;
`endif

    // History tracks the input even during reset, so a level held across
    // reset release is not mistaken for a new edge.
    always_ff @(posedge CLK) begin
        hist_reg <= sampled;
    end

    assign rise = sampled & ~hist_reg & ~RESET;

endmodule

// File: rtl/rat_intr_ctrl.sv
// Edge-triggered interrupt controller feeding the RAT core INTR pin, with
// STATUS/MASK/VECTOR port registers. IRQ_SYNC_EN adds input synchronizers.
module rat_intr_ctrl
    import rat_intr_pkg::*;
#(
    parameter int         N_SRC     = 8,
    parameter logic [7:0] PORT_BASE = 8'h30,
    parameter int         GAP_CYC   = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [N_SRC-1:0] IRQ_SRC,
    input  logic [7:0]       PORT_ID,
    input  logic [7:0]       OUT_PORT,
    input  logic             IO_STRB,
    output logic [7:0]       IN_PORT_DATA,
    output logic             RD_HIT,
    output logic             INTR
);

    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYC - 1);

    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] pending_reg, pending_next;
    logic [N_SRC-1:0] mask_reg, mask_next;
    logic [N_SRC-1:0] masked;
    logic [N_SRC-1:0] clr_bits;
    logic [7:0]       ofs;
    logic             in_range;
    logic             wr_en;
    logic             eoi_wr;
    logic             vec_valid;
    logic [2:0]       vec_id;
    logic [7:0]       vector_val;
    logic [7:0]       rd_data_reg, rd_data_next;
    logic             rd_hit_reg;
    logic             intr_reg;
    intr_state_t      state_reg;
    logic [3:0]       gap_cnt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_edge
            rat_irq_edge u_edge (
                .CLK   (CLK),
                .RESET (RESET),
                .irq   (IRQ_SRC[gi]),
                .rise  (rise[gi])
            );
        end
    endgenerate

    assign masked   = pending_reg & mask_reg;
    assign ofs      = PORT_ID - PORT_BASE;
    assign in_range = (ofs <= OFS_VECTOR);
    assign wr_en    = IO_STRB & in_range;
    assign eoi_wr   = wr_en && (ofs == OFS_VECTOR);

    // Lowest index wins: scan from the top so the last hit is the lowest bit.
    always_comb begin
        vec_id    = '0;
        vec_valid = |masked;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (masked[i]) begin
                vec_id = 3'(i);
            end
        end
        vector_val                = '0;
        vector_val[VEC_VALID_BIT] = vec_valid;
        vector_val[2:0]           = vec_id;
    end

    always_comb begin
        clr_bits  = '0;
        mask_next = mask_reg;
        if (wr_en) begin
            case (ofs)
                OFS_STATUS: clr_bits  = OUT_PORT[N_SRC-1:0];
                OFS_MASK:   mask_next = OUT_PORT[N_SRC-1:0];
                OFS_VECTOR: if (vec_valid) clr_bits[vec_id] = 1'b1;
                default:    ;
            endcase
        end
        // A new edge beats a same-cycle clear.
        pending_next = (pending_reg & ~clr_bits) | rise;
    end

    always_comb begin
        rd_data_next = '0;
        if (in_range) begin
            case (ofs)
                OFS_STATUS: rd_data_next = 8'(pending_reg);
                OFS_MASK:   rd_data_next = 8'(mask_reg);
                OFS_VECTOR: rd_data_next = vector_val;
                default:    rd_data_next = '0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pending_reg <= '0;
            mask_reg    <= '0;
            rd_data_reg <= '0;
            rd_hit_reg  <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            mask_reg    <= mask_next;
            rd_data_reg <= rd_data_next;
            rd_hit_reg  <= in_range;
        end
    end

    // INTR is registered alongside the state so it equals (state == ASSERT).
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg   <= IDLE;
            gap_cnt_reg <= '0;
            intr_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|masked) begin
                        state_reg <= ASSERT;
                        intr_reg  <= 1'b1;
                    end else begin
                        intr_reg  <= 1'b0;
                    end
                end
                ASSERT: begin
                    if (eoi_wr) begin
                        state_reg   <= GAP;
                        gap_cnt_reg <= GAP_LOAD;
                        intr_reg    <= 1'b0;
                    end else if ((pending_next & mask_next) == '0) begin
                        state_reg <= IDLE;
                        intr_reg  <= 1'b0;
                    end else begin
                        intr_reg  <= 1'b1;
                    end
                end
                GAP: begin
                    intr_reg <= 1'b0;
                    if (gap_cnt_reg == '0) begin
                        state_reg <= IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - 4'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    intr_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign IN_PORT_DATA = rd_data_reg;
    assign RD_HIT       = rd_hit_reg;
    assign INTR         = intr_reg;

endmodule

// File: tb/tb_rat_intr_ctrl.sv
// Testbench for rat_intr_ctrl (default build, IRQ_SYNC_EN undefined): directed
// scenarios plus randomized traffic checked cycle by cycle against a model.
module tb_rat_intr_ctrl;

    localparam int         GAP  = 4;
    localparam logic [7:0] BASE = 8'h30;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] irq_src  = 8'h01;
    logic [7:0] port_id  = 8'h00;
    logic [7:0] out_port = 8'h00;
    logic       io_strb  = 1'b0;
    logic [7:0] in_port_data;
    logic       rd_hit;
    logic       intr;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: pending/mask as plain bytes, INTR, and the
    // number of further cycles INTR is held off after an EOI.
    logic [7:0] m_pend, m_mask, m_hist, m_rd;
    logic       m_hit, m_intr;
    int         m_hold;

    rat_intr_ctrl #(
        .N_SRC     (8),
        .PORT_BASE (BASE),
        .GAP_CYC   (GAP)
    ) dut (
        .CLK          (clk),
        .RESET        (reset),
        .IRQ_SRC      (irq_src),
        .PORT_ID      (port_id),
        .OUT_PORT     (out_port),
        .IO_STRB      (io_strb),
        .IN_PORT_DATA (in_port_data),
        .RD_HIT       (rd_hit),
        .INTR         (intr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %02h exp %02h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one clock edge's worth of the controller rules to the model,
    // using the inputs currently presented to the DUT.
    task automatic model_edge();
        logic [7:0] mm, rise, clr, nmask, npend, ofs;
        logic       inr, eoi;
        int         id;
        if (reset) begin
            m_pend = 8'h00; m_mask = 8'h00; m_rd = 8'h00; m_hit = 1'b0;
            m_intr = 1'b0;  m_hold = 0;     m_hist = irq_src;
            return;
        end
        mm = m_pend & m_mask;
        id = -1;
        for (int i = 0; i < 8; i++) begin
            if (mm[i] && id < 0) id = i;
        end
        rise   = irq_src & ~m_hist;
        m_hist = irq_src;
        inr    = (port_id >= BASE) && (port_id <= BASE + 8'd2);
        ofs    = port_id - BASE;
        m_rd   = 8'h00;
        if (inr) begin
            if (ofs == 8'd0)      m_rd = m_pend;
            else if (ofs == 8'd1) m_rd = m_mask;
            else                  m_rd = (id >= 0) ? (8'h80 | 8'(id)) : 8'h00;
        end
        m_hit = inr;
        clr   = 8'h00;
        nmask = m_mask;
        eoi   = 1'b0;
        if (io_strb && inr) begin
            if (ofs == 8'd0)      clr   = out_port;
            else if (ofs == 8'd1) nmask = out_port;
            else begin
                eoi = 1'b1;
                if (id >= 0) clr[id] = 1'b1;
            end
        end
        npend = (m_pend & ~clr) | rise;
        if (m_intr) begin
            if (eoi) begin
                m_intr = 1'b0;
                m_hold = GAP;
            end else begin
                m_intr = ((npend & nmask) != 8'h00);
            end
        end else if (m_hold > 0) begin
            m_hold--;
            m_intr = 1'b0;
        end else begin
            m_intr = (mm != 8'h00);
        end
        m_pend = npend;
        m_mask = nmask;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("intr", {7'd0, intr}, {7'd0, m_intr});
        check("rd_data", in_port_data, m_rd);
        check("rd_hit", {7'd0, rd_hit}, {7'd0, m_hit});
    endtask

    task automatic wr(input logic [7:0] p, input logic [7:0] d);
        port_id  = p;
        out_port = d;
        io_strb  = 1'b1;
        $display("wr port %02h data %02h", p, d);
        tick();
        io_strb  = 1'b0;
        port_id  = 8'h00;
        out_port = 8'h00;
    endtask

    task automatic rd(input logic [7:0] p, input logic [7:0] exp, input string tag);
        port_id = p;
        tick();
        $display("rd port %02h data %02h", p, in_port_data);
        check(tag, in_port_data, exp);
        port_id = 8'h00;
    endtask

    initial begin
        int low;
        int r;

        // Source 0 held high through reset must not register as an edge.
        repeat (2) tick();
        check("rst_intr", {7'd0, intr}, 8'h00);
        check("rst_rd", in_port_data, 8'h00);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("held_src_intr", {7'd0, intr}, 8'h00);
        end
        rd(BASE, 8'h00, "held_src_status");

        // Single source, VECTOR read, EOI and gap.
        wr(BASE + 8'd1, 8'h04);
        irq_src = 8'h05;
        tick();
        check("lat1_intr", {7'd0, intr}, 8'h00);
        tick();
        check("lat2_intr", {7'd0, intr}, 8'h01);
        irq_src = 8'h01;
        rd(BASE + 8'd2, 8'h82, "vec_82");
        wr(BASE + 8'd2, 8'h00);
        check("eoi_drop", {7'd0, intr}, 8'h00);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("gap_low", {7'd0, intr}, 8'h00);
        end
        rd(BASE, 8'h00, "status_after_eoi");

        // Two simultaneous sources: lowest first, second after the gap.
        wr(BASE + 8'd1, 8'hFF);
        irq_src = 8'h23;
        tick();
        tick();
        check("two_src_intr", {7'd0, intr}, 8'h01);
        irq_src = 8'h01;
        rd(BASE + 8'd2, 8'h81, "vec_81");
        wr(BASE + 8'd2, 8'h00);
        low = 1;
        for (int c = 0; c < 20 && intr !== 1'b1; c++) begin
            tick();
            if (intr !== 1'b1) low++;
        end
        check("reassert", {7'd0, intr}, 8'h01);
        check("gap_min", 8'(low >= GAP), 8'h01);
        rd(BASE + 8'd2, 8'h85, "vec_85");
        wr(BASE + 8'd2, 8'h00);
        repeat (8) tick();
        rd(BASE, 8'h00, "status_clear");

        // Edge on the same cycle as a W1C of that bit: the edge wins.
        irq_src  = 8'h09;
        port_id  = BASE;
        out_port = 8'h08;
        io_strb  = 1'b1;
        tick();
        io_strb  = 1'b0;
        port_id  = 8'h00;
        irq_src  = 8'h01;
        rd(BASE, 8'h08, "set_beats_clr");
        wr(BASE, 8'hFF);
        check("w1c_drop", {7'd0, intr}, 8'h00);

        // Masked pending, then enable, then W1C with no gap afterwards.
        wr(BASE + 8'd1, 8'h00);
        irq_src = 8'h41;
        tick();
        irq_src = 8'h01;
        repeat (3) tick();
        check("masked_intr", {7'd0, intr}, 8'h00);
        rd(BASE, 8'h40, "masked_pending");
        wr(BASE + 8'd1, 8'h40);
        check("unmask_lat1", {7'd0, intr}, 8'h00);
        tick();
        check("unmask_lat2", {7'd0, intr}, 8'h01);
        wr(BASE, 8'h40);
        check("w1c_no_gap_drop", {7'd0, intr}, 8'h00);
        irq_src = 8'h41;
        tick();
        irq_src = 8'h01;
        tick();
        check("no_gap_reassert", {7'd0, intr}, 8'h01);

        // Reset mid-operation.
        reset = 1'b1;
        tick();
        check("mid_rst_intr", {7'd0, intr}, 8'h00);
        reset = 1'b0;
        rd(BASE + 8'd1, 8'h00, "mask_after_rst");
        rd(BASE, 8'h00, "status_after_rst");

        // Randomized traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) irq_src = irq_src ^ (8'd1 << $urandom_range(0, 7));
            r        = int'($urandom_range(0, 9));
            port_id  = (r < 8) ? BASE + 8'($urandom_range(0, 2)) : 8'($urandom);
            io_strb  = ($urandom_range(0, 5) == 0);
            out_port = 8'($urandom);
            if (io_strb) $display("cyc %0d wr port %02h data %02h rst %0d", c, port_id, out_port, reset);
            tick();
        end
        reset   = 1'b0;
        io_strb = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
